demux_steer_ctrl: RTL and testbench

Controller that feeds and sequences the 2-way demultiplexer (`A_in`/`Select` → `outB`/`outC`). It accepts a valid/ready input stream, holds one word, and drives the demux data and select lines. Per-channel valid/ready handshakes are exposed to the two downstream consumers. Destinations alternate between channel B and channel C in fixed-length bursts, with an optional lock onto a single channel.

---
 rtl/demux_ctrl_pkg.sv | 19 +
 rtl/demux_burst_counter.sv | 41 ++++
 rtl/demux_steer_ctrl.sv | 106 ++++++++++
 tb/tb_demux_steer_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_ctrl_pkg.sv
// Shared types and constants for the demux steering controller.
// State encoding, channel identifiers and a small state helper.
package demux_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_B = 2'd1,
    HOLD_C = 2'd2
  } state_t;

  localparam logic CH_B = 1'b0;
  localparam logic CH_C = 1'b1;

  // Hold state that corresponds to a destination channel
  function automatic state_t hold_state(input logic ch);
    return (ch == CH_C) ? HOLD_C : HOLD_B;
  endfunction

endpackage

// File: rtl/demux_burst_counter.sv
// Burst sequencer for the demux steering controller.
// Counts captured words and toggles the current destination after
// BURST_LEN words. A locked capture pins the destination and restarts
// the burst, so unlocking continues on the locked channel from count 0.
module demux_burst_counter
  import demux_ctrl_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic advance,
  input  logic lock,
  input  logic lock_sel,
  output logic cur_sel
);

  // BURST_LEN is at most 255, so eight bits always hold the count
  localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

  logic [7:0] count;

  // Advance the burst position on every capture; wrap and switch channel at the end of a burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      cur_sel <= CH_B;
    end else if (advance) begin
      if (lock) begin
        count   <= '0;
        cur_sel <= lock_sel;
      end else if (count == LAST_IDX) begin
        count   <= '0;
        cur_sel <= ~cur_sel;
      end else begin
        count <= count + 8'd1;
      end
    end
  end

endmodule

// File: rtl/demux_steer_ctrl.sv
// Controller feeding a 2-way demux (A_in/Select -> outB/outC).
// Holds one upstream word, drives it onto dmx_a/dmx_sel and offers it
// to channel B or C with a valid/ready handshake. Destinations alternate
// in bursts of BURST_LEN words unless lock_en pins them to lock_sel.
// Optional build macro DEMUX_CTRL_STATS_EN adds per-channel release
// counters (cnt_b, cnt_c) with a synchronous clear (stats_clr).
module demux_steer_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int DATA_W    = 2,
  parameter int BURST_LEN = 4
`ifdef DEMUX_CTRL_STATS_EN
  ,
  parameter int CNT_W     = 8
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              lock_en,
  input  logic              lock_sel,
  output logic [DATA_W-1:0] dmx_a,
  output logic              dmx_sel,
  output logic              b_valid,
  output logic              c_valid,
  input  logic              b_ready,
`ifdef DEMUX_CTRL_STATS_EN
  input  logic              c_ready,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  cnt_b,
  output logic [CNT_W-1:0]  cnt_c
`else
  input  logic              c_ready
`endif
);

  state_t state;
  logic   cur_sel;
  logic   release_b;
  logic   release_c;
  logic   capture;
  logic   dest;

  // Only the addressed channel's ready can release the held word
  assign release_b = (state == HOLD_B) && b_ready;
  assign release_c = (state == HOLD_C) && c_ready;

  // A slot is free when nothing is held or the held word leaves this cycle
  assign in_ready = rst_n && ((state == IDLE) || release_b || release_c);
  assign capture  = in_valid && in_ready;

  // Lock overrides the burst sequence for the word being captured
  assign dest = lock_en ? lock_sel : cur_sel;

  assign b_valid = (state == HOLD_B);
  assign c_valid = (state == HOLD_C);

  demux_burst_counter #(
    .BURST_LEN (BURST_LEN)
  ) u_burst (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (capture),
    .lock     (lock_en),
    .lock_sel (lock_sel),
    .cur_sel  (cur_sel)
  );

  // Hold FSM: capture loads the word and its destination, a bare release returns to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dmx_a   <= '0;
      dmx_sel <= CH_B;
    end else if (capture) begin
      state   <= hold_state(dest);
      dmx_a   <= in_data;
      dmx_sel <= dest;
    end else if (release_b || release_c) begin
      state <= IDLE;
    end
  end

`ifdef DEMUX_CTRL_STATS_EN
  // Release counters per channel; a clear wins over a coinciding release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_b <= '0;
      cnt_c <= '0;
    end else if (stats_clr) begin
      cnt_b <= '0;
      cnt_c <= '0;
    end else begin
      if (release_b) begin
        cnt_b <= cnt_b + CNT_W'(1);
      end
      if (release_c) begin
        cnt_c <= cnt_c + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux_steer_ctrl.sv
// Self-checking bench for demux_steer_ctrl.
// Table of back-to-back burst/lock vectors, hand sequences for reset,
// backpressure and non-addressed ready, then random traffic against a
// reference model. A second instance with BURST_LEN=1 shares the inputs.
`timescale 1ns/1ps
module tb_demux_steer_ctrl;

  localparam int DATA_W    = 2;
  localparam int BURST_LEN = 4;
`ifdef DEMUX_CTRL_STATS_EN
  localparam int CNT_W     = 2;
`endif

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic [1:0]  in_data  = '0;
  logic        in_valid = 1'b0;
  logic        lock_en  = 1'b0;
  logic        lock_sel = 1'b0;
  logic        b_ready  = 1'b0;
  logic        c_ready  = 1'b0;
  logic        in_ready, dmx_sel, b_valid, c_valid;
  logic [1:0]  dmx_a;
  logic        in_ready1, dmx_sel1, b_valid1, c_valid1;
  logic [1:0]  dmx_a1;
`ifdef DEMUX_CTRL_STATS_EN
  logic             stats_clr = 1'b0;
  logic [CNT_W-1:0] cnt_b, cnt_c, cnt_b1, cnt_c1;
`endif

  always #5 clk = ~clk;

  demux_steer_ctrl #(
    .DATA_W    (DATA_W),
`ifdef DEMUX_CTRL_STATS_EN
    .CNT_W     (CNT_W),
`endif
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lock_en   (lock_en),
    .lock_sel  (lock_sel),
    .dmx_a     (dmx_a),
    .dmx_sel   (dmx_sel),
    .b_valid   (b_valid),
    .c_valid   (c_valid),
    .b_ready   (b_ready),
`ifdef DEMUX_CTRL_STATS_EN
    .stats_clr (stats_clr),
    .cnt_b     (cnt_b),
    .cnt_c     (cnt_c),
`endif
    .c_ready   (c_ready)
  );

  demux_steer_ctrl #(
    .DATA_W    (DATA_W),
`ifdef DEMUX_CTRL_STATS_EN
    .CNT_W     (CNT_W),
`endif
    .BURST_LEN (1)
  ) dut_bl1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .lock_en   (lock_en),
    .lock_sel  (lock_sel),
    .dmx_a     (dmx_a1),
    .dmx_sel   (dmx_sel1),
    .b_valid   (b_valid1),
    .c_valid   (c_valid1),
    .b_ready   (b_ready),
`ifdef DEMUX_CTRL_STATS_EN
    .stats_clr (stats_clr),
    .cnt_b     (cnt_b1),
    .cnt_c     (cnt_c1),
`endif
    .c_ready   (c_ready)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: one held slot plus the number of unlocked captures since the last lock
  bit         m_held;
  logic [1:0] m_data;
  bit         m_dest;
  bit         m_base;
  int         m_n;
`ifdef DEMUX_CTRL_STATS_EN
  logic [CNT_W-1:0] m_cnt_b, m_cnt_c;
`endif

  typedef struct {
    logic [1:0] d;
    bit         le;
    bit         ls;
    logic [1:0] ea;
    bit         es;
  } vec_t;

  vec_t       vecs[24];
  logic [4:0] act5, exp5;
  logic [5:0] act6, exp6;

  function automatic bit model_in_ready();
    return rst_n && (!m_held || (m_dest ? c_ready : b_ready));
  endfunction

  task automatic model_reset();
    m_held = 0;
    m_data = '0;
    m_dest = 0;
    m_base = 0;
    m_n    = 0;
`ifdef DEMUX_CTRL_STATS_EN
    m_cnt_b = '0;
    m_cnt_c = '0;
`endif
  endtask

  task automatic applyStimulus(input logic [1:0] d, input logic v, input logic le,
                               input logic ls, input logic br, input logic cr);
    in_data  = d;
    in_valid = v;
    lock_en  = le;
    lock_sel = ls;
    b_ready  = br;
    c_ready  = cr;
    #1;
  endtask

  // Advance the model with the inputs currently applied, then cross one rising edge
  task automatic tick();
    bit rdy, cap, rel, d;
    rdy = model_in_ready();
    rel = m_held && (m_dest ? c_ready : b_ready);
    cap = in_valid && rdy;
`ifdef DEMUX_CTRL_STATS_EN
    if (stats_clr) begin
      m_cnt_b = '0;
      m_cnt_c = '0;
    end else if (rel) begin
      if (m_dest) m_cnt_c = m_cnt_c + 1'b1;
      else        m_cnt_b = m_cnt_b + 1'b1;
    end
`endif
    if (cap) begin
      if (lock_en) begin
        d      = lock_sel;
        m_base = lock_sel;
        m_n    = 0;
      end else begin
        d   = m_base ^ bit'((m_n / BURST_LEN) % 2);
        m_n = m_n + 1;
      end
      m_held = 1;
      m_data = in_data;
      m_dest = d;
    end else if (rel) begin
      m_held = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name);
    act6 = {dmx_a, dmx_sel, b_valid, c_valid, in_ready};
    exp6 = {m_data, m_dest, m_held && !m_dest, m_held && m_dest, model_in_ready()};
    checks++;
    if (act6 !== exp6) begin
      failures++;
      $display("[TB] FAIL %s: got a/sel/bv/cv/rdy=%b required %b", name, act6, exp6);
    end
`ifdef DEMUX_CTRL_STATS_EN
    check_val({name, "_cnt"}, 32'({cnt_b, cnt_c}), 32'({m_cnt_b, m_cnt_c}));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
`ifdef DEMUX_CTRL_STATS_EN
    stats_clr = 1'b0;
`endif
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    model_reset();
    checkOutput("reset_state");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("post_reset");
    check_val("post_reset_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Burst table: 12 words B x4, C x4, B x4; then 6 locked to C; then 4 more C and 2 B
    for (int i = 0; i < 24; i++) begin
      vecs[i].d  = 2'(i % 4);
      vecs[i].ea = 2'(i % 4);
      if (i < 12) begin
        vecs[i].le = 0; vecs[i].ls = 0; vecs[i].es = bit'((i / 4) % 2);
      end else if (i < 18) begin
        vecs[i].le = 1; vecs[i].ls = 1; vecs[i].es = 1;
      end else if (i < 22) begin
        vecs[i].le = 0; vecs[i].ls = 0; vecs[i].es = 1;
      end else begin
        vecs[i].le = 0; vecs[i].ls = 0; vecs[i].es = 0;
      end
    end

    do_reset();

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].d, 1'b1, vecs[i].le, vecs[i].ls, 1'b1, 1'b1);
      check_val("tbl_in_ready", 32'(in_ready), 32'd1);
      tick();
      act5 = {dmx_a, dmx_sel, b_valid, c_valid};
      exp5 = {vecs[i].ea, vecs[i].es, !vecs[i].es, vecs[i].es};
      check_val("tbl_out", 32'(act5), 32'(exp5));
      checkOutput("tbl_model");
      if (i < 12) begin
        act6 = {dmx_a1, dmx_sel1, b_valid1, c_valid1, in_ready1};
        exp6 = {vecs[i].ea, bit'(i % 2), !bit'(i % 2), bit'(i % 2), 1'b1};
        check_val("bl1_out", 32'(act6), 32'(exp6));
      end
    end

    // Backpressure on B with C ready: word 2'b10 must stay put, C never valid
    do_reset();
    applyStimulus(2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check_val("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_model");
      tick();
      check_val("bp_hold", 32'({dmx_a, dmx_sel, b_valid, c_valid}), 32'(5'b10010));
    end
    applyStimulus(2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    check_val("bp_same_cycle_capture", 32'({dmx_a, dmx_sel, b_valid, c_valid}), 32'(5'b01010));
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check_val("bp_drain_keeps_data", 32'({dmx_a, dmx_sel, b_valid, c_valid}), 32'(5'b01000));
    checkOutput("bp_drain_model");

    // Asynchronous reset while a word 2'b11 is held for C
    applyStimulus(2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("pre_rst_hold_c", 32'({dmx_a, dmx_sel, b_valid, c_valid}), 32'(5'b11101));
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst", 32'({c_valid, in_ready, dmx_a, dmx_sel}), 32'd0);
    model_reset();
    checkOutput("async_rst_model");
    #1;
    rst_n = 1'b1;
    #1;
    check_val("rst_release_ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("after_rst_idle");

`ifdef DEMUX_CTRL_STATS_EN
    // Five releases to B wrap a 2-bit counter to 1; a clear on a release gives 0
    do_reset();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(2'(k), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
    end
    check_val("stats_wrap_b", 32'(cnt_b), 32'd1);
    stats_clr = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    stats_clr = 1'b0;
    check_val("stats_clr_on_release", 32'(cnt_b), 32'd0);
    checkOutput("stats_model");
`endif

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 600; k++) begin
`ifdef DEMUX_CTRL_STATS_EN
      stats_clr = ($urandom_range(0, 15) == 0);
`endif
      applyStimulus(2'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                    1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      checkOutput("rand");
      tick();
    end
    checkOutput("rand_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
